// File: rtl/sd_bit_serializer.sv
// sd_bit_serializer: parallel-in, serial-out stage feeding the 1011 sequence
// detector. WIDTH-bit words are accepted over valid/ready and emitted one bit
// per clk on ser_out, with gapless back-to-back words when the next word is
// offered on the final bit of the current one.
//
// Optional feature: define SD_SER_PARITY_EN to append an even-parity bit
// (^word) after each word's data bits, in a dedicated PARITY state.
//
// state  | meaning
// IDLE   | no word in flight, ser_valid=0, ser_out=0, ready for a word
// SHIFT  | emitting data bits, cnt = index of the bit now on ser_out
// PARITY | emitting the parity bit (only with SD_SER_PARITY_EN)

module sd_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SD_SER_PARITY_EN
    localparam logic [1:0] PARITY = 2'd2;
`endif

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             accept;
    logic             head_bit;
`ifdef SD_SER_PARITY_EN
    logic             par_bit;
`endif

    assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);
    assign head_bit = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    // Ready in IDLE and on the final emitted bit, so a word offered then follows with no gap.
    always_comb begin
        in_ready = 1'b0;
`ifdef SD_SER_PARITY_EN
        in_ready = !reset && ((state == IDLE) || (state == PARITY));
`else
        in_ready = !reset && ((state == IDLE) || last_bit);
`endif
    end

    // Serial outputs decoded from state; everything reads as 0 whenever no bit is in flight.
    always_comb begin
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        word_done = 1'b0;
        case (state)
            SHIFT: begin
                ser_out   = head_bit;
                ser_valid = 1'b1;
`ifndef SD_SER_PARITY_EN
                word_done = last_bit;
`endif
            end
`ifdef SD_SER_PARITY_EN
            PARITY: begin
                ser_out   = par_bit;
                ser_valid = 1'b1;
                word_done = 1'b1;
            end
`endif
            default: begin
                ser_out   = 1'b0;
                ser_valid = 1'b0;
                word_done = 1'b0;
            end
        endcase
    end

    // Sequencer: load on accept, shift one bit per cycle, chain or drop to IDLE after the last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= SHIFT;
                        shreg <= in_data;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (cnt == CNT_LAST) begin
`ifdef SD_SER_PARITY_EN
                        state <= PARITY;
`else
                        if (accept) begin
                            shreg <= in_data;
                            cnt   <= '0;
                        end else begin
                            state <= IDLE;
                        end
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (MSB_FIRST != 0)
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                        else
                            shreg <= {1'b0, shreg[WIDTH-1:1]};
                    end
                end
`ifdef SD_SER_PARITY_EN
                PARITY: begin
                    if (accept) begin
                        state <= SHIFT;
                        shreg <= in_data;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SD_SER_PARITY_EN
    // Parity is taken from the word as accepted, so later in_data changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (reset)
            par_bit <= 1'b0;
        else if (accept)
            par_bit <= ^in_data;
    end
`endif

endmodule
